// File: rtl/sqrt_fxp_pkg.sv
// Widths and FSM encoding shared by the digit-by-digit square-root unit and its squarer/checker.
package sqrt_fxp_pkg;
  localparam int ROOT_W    = 15;
  localparam int ROOT_FRAC = 7;
  localparam int NUM_W     = 22;
  localparam int NUM_FRAC  = 6;
  localparam int SQ_W      = 2 * ROOT_W;
  localparam int NXT_W     = SQ_W + 1;
  localparam int ALIGN_SH  = 2 * ROOT_FRAC - NUM_FRAC;
  localparam int CNT_W     = $clog2(ROOT_W);
  localparam int LAST_CNT  = ROOT_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } sqrt_state_t;

  // Bring a Q16.6 radicand onto the Q16.14 grid of R*R.
  function automatic logic [SQ_W-1:0] align_num(input logic [NUM_W-1:0] n);
    return SQ_W'(n) << ALIGN_SH;
  endfunction
endpackage

// File: rtl/fxp_sqrt_squarer_if.sv
// Valid/ready request and result bundle of the squarer/root checker.
interface fxp_sqrt_squarer_if;
  import sqrt_fxp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ROOT_W-1:0] root;
  logic [NUM_W-1:0]  num;
  logic              out_valid;
  logic              out_ready;
  logic [SQ_W-1:0]   sq;
  logic              ok;
  logic              high;
  logic              low;

  modport slave (
    input  in_valid, root, num, out_ready,
    output in_ready, out_valid, sq, ok, high, low
  );

  modport master (
    output in_valid, root, num, out_ready,
    input  in_ready, out_valid, sq, ok, high, low
  );
endinterface

// File: rtl/shift_add_mul_core.sv
// One-bit-per-cycle shift-add multiplier; done is high during the last iteration cycle.
module shift_add_mul_core
  import sqrt_fxp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROOT_W-1:0] a,
  input  logic [ROOT_W-1:0] b,
  output logic [SQ_W-1:0]   prod,
  output logic [ROOT_W-1:0] mcand,
  output logic              done
);
  logic [ROOT_W-1:0] mcand_q;
  logic [ROOT_W-1:0] mplier_q;
  logic [SQ_W-1:0]   acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q;
  logic              last;

  assign last = (cnt_q == CNT_W'(LAST_CNT));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_q <= acc_q + (SQ_W'(mcand_q) << cnt_q);
      mplier_q <= mplier_q >> 1;
      if (last) run_q <= 1'b0;
      else      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign prod  = acc_q;
  assign mcand = mcand_q;
  assign done  = run_q && last;
endmodule

// File: rtl/fxp_sqrt_squarer.sv
// Squares a Q8.7 root and checks it is the truncated square root of the Q16.6 radicand.
//   state    | meaning
//   ST_IDLE  | ready for a new root/radicand pair
//   ST_MUL   | shift-add squaring, one multiplier bit per cycle
//   ST_CHECK | compare R^2 and (R+1)^2 against the aligned radicand
//   ST_DONE  | result presented until the consumer takes it
module fxp_sqrt_squarer
  import sqrt_fxp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fxp_sqrt_squarer_if.slave bus
);
  sqrt_state_t       state_q, state_d;
  logic              accept;
  logic              mul_done;
  logic [SQ_W-1:0]   prod;
  logic [ROOT_W-1:0] r_val;
  logic [SQ_W-1:0]   n_q;
  logic [NXT_W-1:0]  nxt;
  logic              hi, lo;
  logic [SQ_W-1:0]   sq_q;
  logic              ok_q, high_q, low_q;

  assign accept = bus.in_valid && (state_q == ST_IDLE);

  shift_add_mul_core u_mul (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .a     (bus.root),
    .b     (bus.root),
    .prod  (prod),
    .mcand (r_val),
    .done  (mul_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.in_valid)  state_d = ST_MUL;
      ST_MUL:   if (mul_done)      state_d = ST_CHECK;
      ST_CHECK:                    state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // (R+1)^2 = R^2 + 2R + 1; one extra bit holds the 2^30 corner.
  assign nxt = NXT_W'(prod) + (NXT_W'(r_val) << 1) + NXT_W'(1);
  assign hi  = prod > n_q;
  assign lo  = nxt <= NXT_W'(n_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q    <= '0;
      sq_q   <= '0;
      ok_q   <= 1'b0;
      high_q <= 1'b0;
      low_q  <= 1'b0;
    end else begin
      if (accept) n_q <= align_num(bus.num);
      if (state_q == ST_CHECK) begin
        sq_q   <= prod;
        high_q <= hi;
        low_q  <= lo;
        ok_q   <= !hi && !lo;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sq        = sq_q;
  assign bus.ok        = ok_q;
  assign bus.high      = high_q;
  assign bus.low       = low_q;
endmodule

// File: tb/tb_fxp_sqrt_squarer.sv
// Self-checking bench for fxp_sqrt_squarer: directed table, random ops vs. arithmetic model, corner sequences.
module tb_fxp_sqrt_squarer;
  import sqrt_fxp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fxp_sqrt_squarer_if bus();

  fxp_sqrt_squarer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [14:0] root;
    logic [21:0] num;
    logic [29:0] sq;
    logic        ok;
    logic        high;
    logic        low;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the real-valued definitions.
  task automatic model(input logic [14:0] r, input logic [21:0] n,
                       output logic [29:0] sq, output logic ok, output logic hi, output logic lo);
    longint rr, r1, nn;
    rr = longint'(r) * longint'(r);
    r1 = (longint'(r) + 1) * (longint'(r) + 1);
    nn = longint'(n) * 256;
    hi = (rr > nn);
    lo = (r1 <= nn);
    ok = !hi && !lo;
    sq = 30'(rr);
  endtask

  task automatic start_op(input string name, input logic [14:0] r, input logic [21:0] n);
    int w = 0;
    while (!bus.in_ready && w < 40) begin tick(); w++; end
    chk({name, "_in_ready_pre"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.root = r;
    bus.num = n;
    tick();
    bus.in_valid = 1'b0;
    chk({name, "_in_ready_drop"}, bus.in_ready, 0);
  endtask

  task automatic wait_valid(input string name);
    int lat = 0;
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    chk({name, "_latency"}, lat, 16);
  endtask

  task automatic check_res(input string name, input logic [29:0] sq,
                           input logic ok, input logic hi, input logic lo);
    chk({name, "_sq"}, bus.sq, sq);
    chk({name, "_ok"}, bus.ok, ok);
    chk({name, "_high"}, bus.high, hi);
    chk({name, "_low"}, bus.low, lo);
  endtask

  // Hold the result for 'hold' cycles with stray in_valid pulses, then complete the handshake.
  task automatic handshake(input string name, input int hold, input logic [29:0] sq, input logic ok);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.root = 15'd5;
      bus.num = 22'd7;
      tick();
      chk({name, "_hold_valid"}, bus.out_valid, 1);
      chk({name, "_hold_in_ready"}, bus.in_ready, 0);
      chk({name, "_hold_sq"}, bus.sq, sq);
      chk({name, "_hold_ok"}, bus.ok, ok);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, "_valid_drop"}, bus.out_valid, 0);
    chk({name, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  task automatic run_op(input string name, input logic [14:0] r, input logic [21:0] n,
                        input logic [29:0] sq, input logic ok, input logic hi,
                        input logic lo, input int hold);
    start_op(name, r, n);
    wait_valid(name);
    check_res(name, sq, ok, hi, lo);
    handshake(name, hold, sq, ok);
  endtask

  task automatic expect_no_valid(input string name);
    int seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk({name, "_no_valid"}, seen, 0);
    chk({name, "_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    logic [29:0] esq;
    logic        eok, ehi, elo;
    logic [14:0] r;
    logic [21:0] n;
    longint      nl;

    vecs[0] = '{15'd0,     22'd0,       30'd0,          1'b1, 1'b0, 1'b0};
    vecs[1] = '{15'd181,   22'd128,     30'd32761,      1'b1, 1'b0, 1'b0};
    vecs[2] = '{15'd182,   22'd128,     30'd33124,      1'b0, 1'b1, 1'b0};
    vecs[3] = '{15'd180,   22'd128,     30'd32400,      1'b0, 1'b0, 1'b1};
    vecs[4] = '{15'd32767, 22'd4194303, 30'd1073676289, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{15'd128,   22'd64,      30'd16384,      1'b1, 1'b0, 1'b0};
    vecs[6] = '{15'd127,   22'd64,      30'd16129,      1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.root = '0;
    bus.num = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    check_res("rst", 30'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].root, vecs[i].num,
             vecs[i].sq, vecs[i].ok, vecs[i].high, vecs[i].low, 0);

    for (int i = 0; i < 24; i++) begin
      r = 15'($urandom_range(0, 32767));
      if ($urandom_range(0, 2) == 0) begin
        n = 22'($urandom_range(0, 4194303));
      end else begin
        nl = ((longint'(r) * longint'(r)) >> 8) + longint'($urandom_range(0, 4)) - 2;
        if (nl < 0) nl = 0;
        n = 22'(nl);
      end
      model(r, n, esq, eok, ehi, elo);
      run_op($sformatf("rnd%0d", i), r, n, esq, eok, ehi, elo, int'($urandom_range(0, 3)));
    end

    // Backpressure for 5 cycles, then a following operation.
    run_op("bp", 15'd181, 22'd128, 30'd32761, 1'b1, 1'b0, 1'b0, 5);
    run_op("bp_next", 15'd182, 22'd128, 30'd33124, 1'b0, 1'b1, 1'b0, 0);

    // Reset at MUL count 7 discards the operation.
    start_op("midrst", 15'd181, 22'd128);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    check_res("midrst", 30'd0, 1'b0, 1'b0, 1'b0);
    expect_no_valid("midrst");
    run_op("midrst_next", 15'd181, 22'd128, 30'd32761, 1'b1, 1'b0, 1'b0, 0);

    // Reset together with in_valid: nothing is accepted.
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.root = 15'd181;
    bus.num = 22'd128;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    expect_no_valid("rst_and_valid");
    run_op("final", 15'd32767, 22'd4194303, 30'd1073676289, 1'b1, 1'b0, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fxp_sqrt_squarer.md
# fxp_sqrt_squarer

Sequential fixed-point squarer and root checker: the inverse path of the team's digit-by-digit square-root unit. It accepts an unsigned Q8.7 root and the Q16.6 radicand it was computed from. It squares the root with a one-bit-per-cycle shift-add datapath and reports whether the root is the correctly truncated square root of the radicand. It sits beside the square-root unit as a self-check and back-conversion stage, with valid/ready handshakes on both sides.

## Interface
Parameters:
- ROOT_W, 15: root width, unsigned Q8.7.
- ROOT_FRAC, 7: root fraction bits.
- NUM_W, 22: radicand width, unsigned Q16.6.
- NUM_FRAC, 6: radicand fraction bits; must satisfy NUM_FRAC <= 2*ROOT_FRAC.

Ports:
- clk, in, 1: clock. All state changes on the rising edge.
- reset, in, 1: reset, synchronous, active-high.
- in_valid, in, 1: root/num valid.
- in_ready, out, 1: block can accept; high only in IDLE.
- root, in, ROOT_W: candidate root R, integer view (value R/2^7).
- num, in, NUM_W: radicand n, integer view (value n/2^6).
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts result.
- sq, out, 2*ROOT_W (30): R*R, Q16.14.
- ok, out, 1: R^2 <= N < (R+1)^2.
- high, out, 1: R^2 > N (root too large).
- low, out, 1: (R+1)^2 <= N (root too small).

## Operation
- Radicand alignment: N = n << (2*ROOT_FRAC - NUM_FRAC), i.e. n<<8, 30 bits.
- FSM states: IDLE, MUL, CHECK, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: latch root into the multiplicand register and zero-extend the same root into the multiplier shift register; latch N; clear the 30-bit accumulator; clear the 4-bit counter; go to MUL.
- MUL, 15 cycles (count 0..14)
  - If multiplier bit 0 = 1, acc += multiplicand << count.
  - Shift the multiplier right by one.
  - At count 14, go to CHECK.
- CHECK, 1 cycle
  - nxt = acc + (R<<1) + 1, 31 bits. This is (R+1)^2; no overflow because max is 2^30.
  - high = acc > N.
  - low = nxt <= N.
  - ok = !high && !low.
  - sq = acc.
  - Go to DONE.
- DONE
  - out_valid=1; sq/ok/high/low held stable.
  - When out_ready=1, go to IDLE and drop out_valid the next cycle.
- in_valid is ignored outside IDLE; no input queuing.
- high and low are mutually exclusive by construction.
- Arithmetic is unsigned. Every intermediate is at least 31 bits wide where (R+1)^2 is formed; no truncation anywhere.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, sq=0, ok=0, high=0, low=0, counter=0.
- Reset has priority over all transitions, including mid-MUL and DONE. The in-flight operation is discarded and no out_valid is produced for it.
- Latency: accept edge E0 (in_valid && in_ready) → MUL cycles E1..E15 → CHECK at E16 → out_valid high from the cycle after E16.
- That is 17 edges accept-to-valid.
- Throughput: one operation per 18 cycles when out_ready is held high.
- Backpressure: out_valid and all result outputs remain constant while out_ready=0, for any duration.
- in_ready falls the cycle after acceptance and returns the cycle after the DONE handshake completes.
- Simultaneous reset and in_valid: reset wins and nothing is accepted.
- Outputs are registered; no combinational path from inputs to outputs except in_ready, which is decoded from state only.

## Structure
- Shared package sqrt_fxp_pkg holds:
  - ROOT_W, ROOT_FRAC, NUM_W, NUM_FRAC and the derived SQ_W = 2*ROOT_W;
  - ALIGN_SH = 2*ROOT_FRAC - NUM_FRAC;
  - the FSM state encoding, so the square-root unit and this block share one set of widths.
- One sub-module is natural: shift_add_mul_core.
  - Contains the multiplicand/multiplier/accumulator registers and the iteration counter.
  - Interface: start, operands, done pulse.
  - The top holds the FSM, the handshakes and the CHECK comparisons.

## Test plan
- root=0, num=0 → sq=0, ok=1, high=0, low=0; out_valid 17 edges after accept.
- num=128 (2.0), root=181 (1.4140625) → sq=32761 (N=32768, (R+1)^2=33124), ok=1.
- num=128, root=182 → sq=33124, high=1, ok=0. Then root=180 → sq=32400, low=1, ok=0.
- num=4194303 (max), root=32767 → sq=1073676289, ok=1 (N=1073741568 < 2^30); checks the full-width path.
- Hold out_ready=0 for 5 cycles in DONE → outputs and out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready → IDLE next cycle; the next operation is correct.
- Assert reset at MUL count 7 → next cycle IDLE, in_ready=1, out_valid=0, outputs zero. The following num=128/root=181 operation gives ok=1.
